// File: rtl/tdm_pkg.sv
// Definitions shared by the TDM receive-side demux and the future transmit-side serialiser.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        EXPECT_A = 2'd1,
        EXPECT_B = 2'd2
    } tdm_state_e;

    localparam logic SLOT_A = 1'b0;
    localparam logic SLOT_B = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tdm_demux2to1.sv
// De-interleaves an A,B,A,B slot stream into two registered channels with slip detection.
// Optional saturating slip counter enabled by defining TDM_DEMUX_ERRCNT_EN.
module tdm_demux2to1
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    din,
    input  logic                din_valid,
    input  logic                din_sync,
    output logic [WIDTH-1:0]    out_a,
    output logic [WIDTH-1:0]    out_b,
    output logic                valid_a,
    output logic                valid_b,
    output logic                pair_valid,
    output logic                locked,
    output logic                slip_err,
    output logic [ERRCNT_W-1:0] err_count
);

    tdm_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic             valid_a_q, valid_a_d;
    logic             valid_b_q, valid_b_d;
    logic             pair_q, pair_d;
    logic             slip_q, slip_d;
    logic             slot_id;

    assign slot_id = din_sync ? SLOT_A : SLOT_B;

    always_comb begin
        state_d   = state_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        valid_a_d = 1'b0;
        valid_b_d = 1'b0;
        pair_d    = 1'b0;
        slip_d    = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (slot_id == SLOT_A) begin
                        out_a_d   = din;
                        valid_a_d = 1'b1;
                        state_d   = EXPECT_B;
                    end
                end
                EXPECT_B: begin
                    if (slot_id == SLOT_B) begin
                        out_b_d   = din;
                        valid_b_d = 1'b1;
                        pair_d    = 1'b1;
                        state_d   = EXPECT_A;
                    end else begin
                        // Repeated sync: restart the pair on the newer A word.
                        slip_d    = 1'b1;
                        out_a_d   = din;
                        valid_a_d = 1'b1;
                    end
                end
                EXPECT_A: begin
                    if (slot_id == SLOT_A) begin
                        out_a_d   = din;
                        valid_a_d = 1'b1;
                        state_d   = EXPECT_B;
                    end else begin
                        slip_d  = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            out_a_q   <= '0;
            out_b_q   <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            pair_q    <= 1'b0;
            slip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            pair_q    <= pair_d;
            slip_q    <= slip_d;
        end
    end

    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign valid_a    = valid_a_q;
    assign valid_b    = valid_b_q;
    assign pair_valid = pair_q;
    assign slip_err   = slip_q;
    assign locked     = (state_q != HUNT);

`ifdef TDM_DEMUX_ERRCNT_EN
    // Counts on the same edge that raises slip_err, so both update together.
    sat_counter #(
        .W(ERRCNT_W)
    ) u_errcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (slip_d),
        .count (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_tdm_demux2to1.sv
// Scoreboard bench for tdm_demux2to1: directed slot vectors with hand-computed responses.
module tb_tdm_demux2to1;

    localparam int WIDTH    = 8;
    localparam int ERRCNT_W = 2;
`ifdef TDM_DEMUX_ERRCNT_EN
    localparam int ERR_MAX = 3;
`else
    localparam int ERR_MAX = 0;
`endif

    typedef struct packed {
        logic       va;
        logic       vb;
        logic       pv;
        logic       slip;
        logic       lock;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] err;
    } obs_t;

    logic                clk;
    logic                rst_n;
    logic [WIDTH-1:0]    din;
    logic                din_valid;
    logic                din_sync;
    logic [WIDTH-1:0]    out_a;
    logic [WIDTH-1:0]    out_b;
    logic                valid_a;
    logic                valid_b;
    logic                pair_valid;
    logic                locked;
    logic                slip_err;
    logic [ERRCNT_W-1:0] err_count;

    int   total = 0;
    int   bad   = 0;
    int   exp_err = 0;
    obs_t sb_q[$];

    tdm_demux2to1 #(
        .WIDTH    (WIDTH),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_sync   (din_sync),
        .out_a      (out_a),
        .out_b      (out_b),
        .valid_a    (valid_a),
        .valid_b    (valid_b),
        .pair_valid (pair_valid),
        .locked     (locked),
        .slip_err   (slip_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.va   = valid_a;
        o.vb   = valid_b;
        o.pv   = pair_valid;
        o.slip = slip_err;
        o.lock = locked;
        o.a    = out_a;
        o.b    = out_b;
        o.err  = err_count;
        return o;
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got va=%b vb=%b pv=%b slip=%b lock=%b a=%h b=%h err=%0d, expected va=%b vb=%b pv=%b slip=%b lock=%b a=%h b=%h err=%0d",
                     name, act.va, act.vb, act.pv, act.slip, act.lock, act.a, act.b, act.err,
                     exp.va, exp.vb, exp.pv, exp.slip, exp.lock, exp.a, exp.b, exp.err);
        end
    endtask

    function automatic obs_t mk(input logic va, input logic vb, input logic pv, input logic slip,
                                input logic lock, input logic [7:0] a, input logic [7:0] b);
        obs_t o;
        o.va   = va;
        o.vb   = vb;
        o.pv   = pv;
        o.slip = slip;
        o.lock = lock;
        o.a    = a;
        o.b    = b;
        o.err  = exp_err[1:0];
        return o;
    endfunction

    // Monitor: every strobe cycle must match the oldest queued expectation.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (valid_a || valid_b || slip_err)) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got va=%b vb=%b pv=%b slip=%b, expected no strobe",
                             valid_a, valid_b, pair_valid, slip_err);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_cycle", observe(), e);
                end
            end
        end
    end

    // Called at a negedge; leaves din_valid=1 so consecutive calls are back-to-back.
    task automatic slot(input string name, input logic [7:0] d, input logic s,
                        input logic va, input logic vb, input logic pv, input logic slip,
                        input logic lock, input logic [7:0] a, input logic [7:0] b);
        obs_t e;
        din       = d;
        din_sync  = s;
        din_valid = 1'b1;
        if (slip && exp_err < ERR_MAX) exp_err++;
        e = mk(va, vb, pv, slip, lock, a, b);
        if (va || vb || slip) sb_q.push_back(e);
        @(negedge clk);
        if (!(va || vb || slip)) chk(name, observe(), e);
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        din_sync  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        din_valid = 1'b0;
        din_sync  = 1'b0;
        rst_n     = 1'b0;
        exp_err   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(name, observe(), mk(0, 0, 0, 0, 0, 8'h00, 8'h00));
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        din_sync  = 1'b0;
        @(negedge clk);
        do_reset("reset_state");

        // Clean back-to-back stream
        slot("clean_a0", 8'h11, 1, 1, 0, 0, 0, 1, 8'h11, 8'h00);
        slot("clean_b0", 8'h22, 0, 0, 1, 1, 0, 1, 8'h11, 8'h22);
        slot("clean_a1", 8'h33, 1, 1, 0, 0, 0, 1, 8'h33, 8'h22);
        slot("clean_b1", 8'h44, 0, 0, 1, 1, 0, 1, 8'h33, 8'h44);
        idle(2);
        chk("idle_hold", observe(), mk(0, 0, 0, 0, 1, 8'h33, 8'h44));

        // Leading garbage while hunting
        do_reset("reset_again");
        slot("garbage0", 8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        slot("garbage1", 8'h66, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        slot("lock_a",   8'h11, 1, 1, 0, 0, 0, 1, 8'h11, 8'h00);
        slot("lock_b",   8'h22, 0, 0, 1, 1, 0, 1, 8'h11, 8'h22);

        // Double sync
        slot("dbl_a",    8'h11, 1, 1, 0, 0, 0, 1, 8'h11, 8'h22);
        slot("dbl_slip", 8'h77, 1, 1, 0, 0, 1, 1, 8'h77, 8'h22);
        slot("dbl_b",    8'h22, 0, 0, 1, 1, 0, 1, 8'h77, 8'h22);

        // Missing sync when locked
        slot("miss_a",    8'h33, 1, 1, 0, 0, 0, 1, 8'h33, 8'h22);
        slot("miss_b",    8'h44, 0, 0, 1, 1, 0, 1, 8'h33, 8'h44);
        slot("miss_slip", 8'h99, 0, 0, 0, 0, 1, 0, 8'h33, 8'h44);
        idle(1);

        // Gap inside a pair, then asynchronous reset mid-pair
        slot("gap_a", 8'h11, 1, 1, 0, 0, 0, 1, 8'h11, 8'h44);
        idle(5);
        chk("gap_hold", observe(), mk(0, 0, 0, 0, 1, 8'h11, 8'h44));
        slot("gap_b", 8'h22, 0, 0, 1, 1, 0, 1, 8'h11, 8'h22);
        slot("new_a", 8'h55, 1, 1, 0, 0, 0, 1, 8'h55, 8'h22);
        din_valid = 1'b0;
        din_sync  = 1'b0;
        #2 rst_n  = 1'b0;
        exp_err   = 0;
        #1 chk("async_reset", observe(), mk(0, 0, 0, 0, 0, 8'h00, 8'h00));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", observe(), mk(0, 0, 0, 0, 0, 8'h00, 8'h00));

        // Five consecutive slips exercise counter saturation
        slot("sat_a",  8'h11, 1, 1, 0, 0, 0, 1, 8'h11, 8'h00);
        slot("sat_s1", 8'h12, 1, 1, 0, 0, 1, 1, 8'h12, 8'h00);
        slot("sat_s2", 8'h13, 1, 1, 0, 0, 1, 1, 8'h13, 8'h00);
        slot("sat_s3", 8'h14, 1, 1, 0, 0, 1, 1, 8'h14, 8'h00);
        slot("sat_s4", 8'h15, 1, 1, 0, 0, 1, 1, 8'h15, 8'h00);
        slot("sat_s5", 8'h16, 1, 1, 0, 0, 1, 1, 8'h16, 8'h00);
        slot("sat_b",  8'h27, 0, 0, 1, 1, 0, 1, 8'h16, 8'h27);
        idle(3);
        chk("final_hold", observe(), mk(0, 0, 0, 0, 1, 8'h16, 8'h27));

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
